// File: rtl/shift_add_mul_if.sv
// Operand/result handshake bundle for shift_add_mul: input side (in_*, a, b,
// signed_mode) and output side (out_*, product).
interface shift_add_mul_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 signed_mode;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, signed_mode, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, signed_mode, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/shift_add_mul.sv
// Radix-2 shift-and-add multiplier around one CLAdder. The signed path
// (magnitudes, neg flag, FIX state) is built only with SHIFT_ADD_MUL_SIGNED_EN.
module CLAdder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout
);
    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;

    assign w_g = in1 & in2;
    assign w_p = in1 ^ in2;

    // 4-bit lookahead groups, group carries rippled between nibbles
    always_comb begin
        logic       c0;
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        out = '0;
        c0  = cin;
        g   = '0;
        p   = '0;
        c   = '0;
        for (int unsigned grp = 0; grp < WIDTH / 4; grp++) begin
            g = 4'(w_g >> (grp * 4));
            p = 4'(w_p >> (grp * 4));
            c[0] = c0;
            c[1] = g[0] | (p[0] & c0);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
            c0   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c0);
            out  = out | (WIDTH'(p ^ c) << (grp * 4));
        end
        cout = c0;
    end
endmodule

module shift_add_mul #(
    parameter int unsigned WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    shift_add_mul_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_width_check
        $error("shift_add_mul: unsupported WIDTH %0d (legal: 4, 8, 16, 32)", WIDTH);
    end

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_h;
    logic [WIDTH-1:0] r_l;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_neg;

    assign w_addend = r_l[0] ? r_m : '0;

    CLAdder #(.WIDTH(WIDTH)) u_add (
        .in1  (r_h),
        .in2  (w_addend),
        .cin  (1'b0),
        .out  (w_sum),
        .cout (w_cout)
    );

`ifdef SHIFT_ADD_MUL_SIGNED_EN
    logic [2*WIDTH-1:0] w_negprod;

    // |min| wraps to itself, which is the correct WIDTH-bit unsigned magnitude
    assign w_mag_a   = (bus.signed_mode && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign w_mag_b   = (bus.signed_mode && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
    assign w_neg     = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    assign w_negprod = ~{r_h, r_l} + 1'b1;
`else
    logic w_unused;

    assign w_mag_a  = bus.a;
    assign w_mag_b  = bus.b;
    assign w_neg    = 1'b0;
    assign w_unused = ^{bus.signed_mode, r_neg};
`endif

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.product   = {r_h, r_l};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_h     <= '0;
            r_l     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_m     <= w_mag_a;
                        r_h     <= '0;
                        r_l     <= w_mag_b;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_neg   <= w_neg;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // {cout, sum, L} >> 1: the adder carry becomes the new H MSB
                    r_h <= {w_cout, w_sum[WIDTH-1:1]};
                    r_l <= {w_sum[0], r_l[WIDTH-1:1]};
                    if (r_cnt == '0) begin
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                        r_state <= FIX;
`else
                        r_state <= DONE;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef SHIFT_ADD_MUL_SIGNED_EN
                FIX: begin
                    if (r_neg) begin
                        {r_h, r_l} <= w_negprod;
                    end
                    r_state <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_add_mul.sv
// Bench for shift_add_mul at WIDTH 32, 8 and 4; a product model and a
// per-cycle output compare, plus literal expectations from directed vectors.
module tb_shift_add_mul;
`ifdef SHIFT_ADD_MUL_SIGNED_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rstv;
    logic [2:0]  iv;
    logic [2:0]  smv;
    logic [2:0]  ordy;
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [63:0] prod [3];

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    shift_add_mul_if #(.WIDTH(32)) if32 ();
    shift_add_mul_if #(.WIDTH(8))  if8 ();
    shift_add_mul_if #(.WIDTH(4))  if4 ();

    shift_add_mul #(.WIDTH(32)) u32 (.clk(clk), .rst(rstv[0]), .bus(if32));
    shift_add_mul #(.WIDTH(8))  u8  (.clk(clk), .rst(rstv[1]), .bus(if8));
    shift_add_mul #(.WIDTH(4))  u4  (.clk(clk), .rst(rstv[2]), .bus(if4));

    assign if32.in_valid = iv[0];   assign if8.in_valid = iv[1];   assign if4.in_valid = iv[2];
    assign if32.signed_mode = smv[0]; assign if8.signed_mode = smv[1]; assign if4.signed_mode = smv[2];
    assign if32.out_ready = ordy[0]; assign if8.out_ready = ordy[1]; assign if4.out_ready = ordy[2];
    assign if32.a = av[0];          assign if8.a = av[1][7:0];     assign if4.a = av[2][3:0];
    assign if32.b = bv[0];          assign if8.b = bv[1][7:0];     assign if4.b = bv[2][3:0];
    assign ir = {if4.in_ready, if8.in_ready, if32.in_ready};
    assign ov = {if4.out_valid, if8.out_valid, if32.out_valid};
    assign prod[0] = if32.product;
    assign prod[1] = {48'b0, if8.product};
    assign prod[2] = {56'b0, if4.product};

    function automatic int unsigned wk(int k);
        case (k)
            0:       return 32;
            1:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int unsigned lat(int k);
        return wk(k) + (SB ? 1 : 0);
    endfunction

    // Exact integer product of the operands as seen at width w
    function automatic logic [63:0] model(int unsigned w, logic [31:0] a_in, logic [31:0] b_in, logic s);
        logic [31:0] a;
        logic [31:0] b;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        a = a_in;
        b = b_in;
        if (w < 32) begin
            a = a & ((32'd1 << w) - 32'd1);
            b = b & ((32'd1 << w) - 32'd1);
        end
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
        if (s && SB) begin
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
        end
        p = 64'(sa * sb);
        if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
        return p;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: track accepted operations at the clock edge
    logic [2:0]  pend = '0;
    logic [2:0]  seen = '0;
    logic [63:0] expv [3];
    int          acc [3];
    int          acc_prev [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            expv[k] = '0; acc[k] = 0; acc_prev[k] = 0;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (rstv[k] === 1'b1) begin
                pend[k] = 1'b0;
            end else if (iv[k] === 1'b1 && ir[k] === 1'b1) begin
                pend[k]     = 1'b1;
                seen[k]     = 1'b0;
                expv[k]     = model(wk(k), av[k], bv[k], smv[k]);
                acc_prev[k] = acc[k];
                acc[k]      = cyc;
            end else if (ov[k] === 1'b1 && ordy[k] === 1'b1) begin
                pend[k] = 1'b0;
            end
        end
    end

    // Compare: every cycle a result is presented
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rstv[k] !== 1'b1 && ov[k] === 1'b1) begin
                check("valid_has_op", 64'(pend[k]), 64'd1);
                check("model_product", prod[k], expv[k]);
                check("in_ready_low_in_done", 64'(ir[k]), 64'd0);
                if (!seen[k]) begin
                    seen[k] = 1'b1;
                    check("latency", 64'(cyc - acc[k]), 64'(lat(k)));
                end
            end
        end
    end

    task automatic issue(int k, logic [31:0] a, logic [31:0] b, logic s, bit keep);
        bit ok;
        ok = 1'b0;
        av[k] = a; bv[k] = b; smv[k] = s; iv[k] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (ir[k] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_chk++; n_err++;
            $display("FAIL accept_timeout: dut %0d in_ready stayed 0, expected 1", k);
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) iv[k] = 1'b0;
    endtask

    task automatic wait_result(int k, string nm, logic [63:0] exp);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ov[k] === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (found) check(nm, prod[k], exp);
        else begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: out_valid stayed 0, expected 1", nm);
        end
    endtask

    initial begin
        bit spurious;
        rstv = '1; iv = '0; smv = '0; ordy = '1;
        for (int k = 0; k < 3; k++) begin av[k] = '0; bv[k] = '0; end
        repeat (3) @(negedge clk);
        rstv = '0;
        for (int k = 0; k < 3; k++) begin
            check("reset_in_ready", 64'(ir[k]), 64'd1);
            check("reset_out_valid", 64'(ov[k]), 64'd0);
            check("reset_product", prod[k], 64'd0);
        end

        // WIDTH=32 unsigned max, then signed vectors (unsigned build ignores signed_mode)
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_result(0, "umax32", 64'hFFFF_FFFE_0000_0001);
        issue(0, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        wait_result(0, "neg3x5", SB ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1);
        issue(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        wait_result(0, "minxmin", 64'h4000_0000_0000_0000);

        // WIDTH=4 backpressure with in_valid pulsing
        ordy[2] = 1'b0;
        issue(2, 32'hF, 32'hF, 1'b0, 1'b0);
        wait_result(2, "bp_first", 64'hE1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv[2] = i[0]; av[2] = 32'(i); bv[2] = 32'd3;
            check("bp_out_valid", 64'(ov[2]), 64'd1);
            check("bp_in_ready", 64'(ir[2]), 64'd0);
            check("bp_product", prod[2], 64'hE1);
        end
        iv[2] = 1'b0; ordy[2] = 1'b1;
        @(negedge clk);
        check("bp_release", 64'(ov[2]), 64'd0);
        issue(2, 32'h8, 32'h8, 1'b1, 1'b0);
        wait_result(2, "w4_min", 64'h40);
        issue(2, 32'hD, 32'h5, 1'b1, 1'b0);
        wait_result(2, "w4_neg", SB ? 64'hF1 : 64'h41);

        // WIDTH=8 zero operand then back-to-back with in_valid/out_ready high
        ordy[1] = 1'b1;
        issue(1, 32'h00, 32'hAB, 1'b0, 1'b1);
        av[1] = 32'h12; bv[1] = 32'h34;
        wait_result(1, "zero", 64'h0000);
        issue(1, 32'h12, 32'h34, 1'b0, 1'b0);
        wait_result(1, "b2b", 64'h03A8);
        check("b2b_spacing", 64'(acc[1] - acc_prev[1]), SB ? 64'd11 : 64'd10);

        // WIDTH=8 reset during the third BUSY cycle
        issue(1, 32'd7, 32'd9, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rstv[1] = 1'b1;
        @(negedge clk);
        rstv[1] = 1'b0;
        check("rst_in_ready", 64'(ir[1]), 64'd1);
        check("rst_out_valid", 64'(ov[1]), 64'd0);
        check("rst_product", prod[1], 64'd0);
        spurious = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov[1] === 1'b1) spurious = 1'b1;
        end
        check("rst_no_result", 64'(spurious), 64'd0);
        issue(1, 32'd7, 32'd9, 1'b0, 1'b0);
        wait_result(1, "after_rst", 64'h003F);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
